// File: rtl/chacha_inv_core.sv
// Iterative inverse ChaCha double-round: undoes ROUNDS double rounds, one inverse
// half-round per enabled cycle, with valid/ready handshakes on input and output.

module chacha_inv_qr #(
    parameter int N = 32
) (
    input  logic [3:0][N-1:0] x,
    output logic [3:0][N-1:0] y
);
    function automatic logic [N-1:0] rotr(input logic [N-1:0] v, input int r);
        return (v >> r) | (v << (N - r));
    endfunction

    logic [N-1:0] a, b, c, d;

    // Forward QR steps replayed backwards: xor-then-rotate becomes rotr-then-xor, adds become subtracts.
    always_comb begin
        a = x[0];
        b = x[1];
        c = x[2];
        d = x[3];
        b = rotr(b, 7) ^ c;
        c = c - d;
        d = rotr(d, 8) ^ a;
        a = a - b;
        b = rotr(b, 12) ^ c;
        c = c - d;
        d = rotr(d, 16) ^ a;
        a = a - b;
        y = {d, c, b, a};
    end
endmodule

module chacha_inv_core #(
    parameter int N      = 32,
    parameter int ROUNDS = 10
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clk_en,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [16*N-1:0] in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [16*N-1:0] out
);
    localparam int CW = $clog2(2 * ROUNDS + 1);
    localparam logic [CW-1:0] LAST = CW'(2 * ROUNDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  st, st_nxt;
    logic [CW-1:0]           cnt;
    logic [15:0][N-1:0]      s, s_nxt;
    logic [3:0][3:0][N-1:0]  qi, qo;

    // Word index of QR lane k, operand j. Even steps use diagonals, odd steps columns.
    function automatic logic [3:0] wi(input int k, input int j, input logic odd);
        int col;
        col = odd ? k : (k + j) % 4;
        return 4'(4 * j + col);
    endfunction

    always_comb begin
        qi = '0;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++)
                qi[k][j] = s[wi(k, j, cnt[0])];
    end

    for (genvar k = 0; k < 4; k++) begin : g_qr
        chacha_inv_qr #(.N(N)) u_qr (
            .x(qi[k]),
            .y(qo[k])
        );
    end

    always_comb begin
        s_nxt = s;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++)
                s_nxt[wi(k, j, cnt[0])] = qo[k][j];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            st <= IDLE;
        else if (clk_en)
            st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            IDLE:    if (in_valid)     st_nxt = RUN;
            RUN:     if (cnt == LAST)  st_nxt = DONE;
            DONE:    if (out_ready)    st_nxt = IDLE;
            default:                   st_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (st == IDLE);
        out_valid = (st == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s   <= '0;
            cnt <= '0;
        end else if (clk_en) begin
            if (st == IDLE && in_valid) begin
                s   <= in;
                cnt <= '0;
            end else if (st == RUN) begin
                s   <= s_nxt;
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign out = s;
endmodule

// File: tb/tb_chacha_inv_core.sv
// Directed bench for chacha_inv_core: RFC 7539 vector, gating, back-pressure,
// reset abort, input noise during RUN, and round-trips through a forward model.

module tb_chacha_inv_core;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         clk_en = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready, out_valid;
    logic [511:0] din = '0;
    logic [511:0] dout;

    int checks = 0;
    int errors = 0;

    chacha_inv_core #(.N(32), .ROUNDS(10)) dut (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
        .in_valid(in_valid), .in_ready(in_ready), .in(din),
        .out_valid(out_valid), .out_ready(out_ready), .out(dout)
    );

    always #5 clk = ~clk;

    localparam logic [511:0] RFC_IN = {
        32'h4e3c50a2, 32'h9e83d0cb, 32'hb04e16de, 32'hd19c12b4,
        32'h82e46ebd, 32'heabda8fc, 32'hf29489f3, 32'h335271c2,
        32'h3f5ec7b7, 32'h8fa018fc, 32'hfc62bb2f, 32'hc4f2d0c7,
        32'h5950bb2f, 32'ha67ae21e, 32'he238d763, 32'h837778ab};
    localparam logic [511:0] RFC_OUT = {
        32'h00000000, 32'h4a000000, 32'h09000000, 32'h00000001,
        32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
        32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100,
        32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] v, input int r);
        return (v << r) | (v >> (32 - r));
    endfunction

    function automatic logic [15:0][31:0] fqr(input logic [15:0][31:0] s,
                                              input int a, input int b, input int c, input int d);
        s[a] = s[a] + s[b]; s[d] = rotl(s[d] ^ s[a], 16);
        s[c] = s[c] + s[d]; s[b] = rotl(s[b] ^ s[c], 12);
        s[a] = s[a] + s[b]; s[d] = rotl(s[d] ^ s[a], 8);
        s[c] = s[c] + s[d]; s[b] = rotl(s[b] ^ s[c], 7);
        return s;
    endfunction

    function automatic logic [511:0] fwd(input logic [511:0] v, input int rounds);
        logic [15:0][31:0] s;
        s = v;
        for (int r = 0; r < rounds; r++) begin
            s = fqr(s, 0, 4, 8, 12); s = fqr(s, 1, 5, 9, 13);
            s = fqr(s, 2, 6, 10, 14); s = fqr(s, 3, 7, 11, 15);
            s = fqr(s, 0, 5, 10, 15); s = fqr(s, 1, 6, 11, 12);
            s = fqr(s, 2, 7, 8, 13);  s = fqr(s, 3, 4, 9, 14);
        end
        return s;
    endfunction

    // Accept one state, then step until out_valid, counting enabled edges after accept.
    task automatic run(input logic [511:0] st, input bit gate, input bit noise,
                       output int en_edges, output bit got);
        @(negedge clk);
        din = st; in_valid = 1'b1; clk_en = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        en_edges = 0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            clk_en = gate ? 1'($urandom_range(0, 1)) : 1'b1;
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                for (int w = 0; w < 16; w++) din[w*32 +: 32] = $urandom;
            end
            @(posedge clk); #1;
            if (clk_en) en_edges++;
            if (out_valid) got = 1'b1;
        end
        in_valid = 1'b0;
        clk_en = 1'b1;
    endtask

    task automatic handoff(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_in_ready"}, 512'(in_ready), 512'd1);
        chk({tag, "_out_valid"}, 512'(out_valid), 512'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        int  edges;
        bit  got;
        logic [511:0] orig;

        #1;
        chk("rst_in_ready", 512'(in_ready), 512'd1);
        chk("rst_out_valid", 512'(out_valid), 512'd0);
        chk("rst_out", dout, '0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;

        run(RFC_IN, 1'b0, 1'b0, edges, got);
        chk("rfc_got", 512'(got), 512'd1);
        chk("rfc_latency", 512'(edges), 512'd20);
        chk("rfc_out", dout, RFC_OUT);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            chk("bp_out", dout, RFC_OUT);
            chk("bp_in_ready", 512'(in_ready), 512'd0);
            chk("bp_out_valid", 512'(out_valid), 512'd1);
        end
        handoff("rfc");

        run(RFC_IN, 1'b1, 1'b0, edges, got);
        chk("gate_latency", 512'(edges), 512'd20);
        chk("gate_out", dout, RFC_OUT);
        handoff("gate");

        run(RFC_IN, 1'b0, 1'b1, edges, got);
        chk("noise_latency", 512'(edges), 512'd20);
        chk("noise_out", dout, RFC_OUT);
        handoff("noise");

        for (int t = 0; t < 8; t++) begin
            for (int w = 0; w < 16; w++) orig[w*32 +: 32] = $urandom;
            run(fwd(orig, 10), t[0], 1'b0, edges, got);
            chk("rt_latency", 512'(edges), 512'd20);
            chk("rt_out", dout, orig);
            handoff("rt");
        end

        @(negedge clk);
        din = RFC_IN; in_valid = 1'b1; clk_en = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_out_valid", 512'(out_valid), 512'd0);
        chk("abort_in_ready", 512'(in_ready), 512'd1);
        chk("abort_out", dout, '0);
        @(negedge clk) reset_n = 1'b1;
        run(RFC_IN, 1'b0, 1'b0, edges, got);
        chk("rerun_latency", 512'(edges), 512'd20);
        chk("rerun_out", dout, RFC_OUT);
        handoff("rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
